ls_agu_p1: RTL and testbench
============================

Name: ls_agu_p1

Overview:
Parametrised load/store address-generation stage, successor to the fixed-width LS issue stage. Accepts scheduled LS instructions and issues register-file reads. Decodes the LS function, computes the effective address, and formats store lanes and byte enables. Presents a registered LS packet to the LSU with full valid/ready back-pressure and pipeline flush; sits between the LS scheduler port and the LSU queue.

Parameters:
PREG_W, 7, physical register index width (rs1/rs2/rd)
TAG_W, 6, ROB tag width carried with each op

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
instr_i  in  32  raw instruction word
rs1_i  in  PREG_W  physical base register
rs2_i  in  PREG_W  physical store-data register
rd_i  in  PREG_W  physical load destination
tag_i  in  TAG_W  ROB tag
valid_i  in  1  input valid
ready_i  out  1  input ready
flush_i  in  1  kill all in-flight ops
addra  out  PREG_W  regfile read addr A, = rs1_i (combinational)
addrb  out  PREG_W  regfile read addr B, = rs2_i (combinational)
dataa  in  32  regfile data A, valid the cycle after addra
datab  in  32  regfile data B, valid the cycle after addrb
valid_o  out  1  output packet valid
ready_o  in  1  LSU ready
ls_func_o  out  4  NOP=0 LB=1 LH=2 LW=3 LBU=4 LHU=5 SB=6 SH=7 SW=8
addr_o  out  32  effective address
data_o  out  32  lane-replicated store data (0 for loads)
be_o  out  4  byte enables (0 for NOP)
rd_o  out  PREG_W  destination
tag_o  out  TAG_W  ROB tag
misalign_o  out  1  misaligned access (see Optional Feature)

Behaviour:
- Reset (async, reset=0): all valid flags (S0, hold, output) cleared; valid_o=0; ls_func_o=0; addr_o, data_o, be_o, rd_o, tag_o, misalign_o = 0.
- Pipeline: S0 register (decoded fields, imm, tag) then output register. Accept-to-valid_o latency 2 cycles; throughput 1 op/cycle with ready_o=1.
- advance = valid0 && (!valid_o || ready_o). ready_i = !flush_i && (!valid0 || advance). Accept = valid_i && ready_i.
- Decode at accept: opcode LOAD (0000011) or STORE (0100011) and funct3 gives ls_func. Any other opcode, or unsupported funct3 (load 3/6/7, store >=3), gives NOP. A NOP is still passed to the output as valid so the ROB can resolve the tag.
- imm: load = sign-extended instr[31:20]; store = sign-extended {instr[31:25], instr[11:7]}. addr = rs1val + imm, modulo 2^32.
- Operand hold: regfile data is valid only the cycle after accept. If S0 is valid and does not advance in that cycle, dataa/datab are captured into hold regs (hold_vld=1). While hold_vld=1, hold values are used instead of dataa/datab. hold_vld clears on advance.
- Store formatting: SB gives data_o={4{rs2[7:0]}}, be=4'b0001<<addr[1:0]. SH gives {2{rs2[15:0]}}, be=4'b0011<<{addr[1],1'b0}. SW gives rs2, be=4'b1111.
- Loads: be by size as for stores; data_o=0.
- Output register updates only on advance. If !advance && ready_o, valid_o drops to 0. While valid_o=1 && ready_o=0, all outputs are held stable.
- flush_i (synchronous): at the next edge, valid0, hold_vld and valid_o are cleared regardless of ready_o; ready_i=0 during the flush cycle, so a simultaneous valid_i is not accepted. Flush has priority over advance.
- Simultaneous accept and advance: S0 is overwritten with the new op in the same edge.

Optional Feature:
Macro LS_MISALIGN_EN.
- Defined: an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]!=0, produces ls_func_o=NOP, be_o=0 and misalign_o=1. addr_o still carries the computed address for the trap value. Tag and valid behave as normal.
- Undefined: misalign_o is tied to 0. ls_func_o is unaffected by alignment, and be_o is computed from the low address bits as specified above, so the LSU handles the access.

Test Plan:
- LW x: instr=0x0042A183 (lw, imm=4), dataa=0x1000 on cycle+1, ready_o=1 -> after 2 cycles valid_o=1, ls_func=3, addr=0x1004, be=4'hF, data_o=0.
- SB: imm=-1, dataa=0x2001, datab=0xDEADBEAB -> ls_func=6, addr=0x2000, data_o=0xABABABAB, be=4'b0001.
- Back-pressure: issue SH (dataa=0x3002, datab=0x1234) then LW; hold ready_o=0 for 5 cycles while the regfile drives garbage. First: addr=0x3002, be=4'b1100, data_o=0x12341234, outputs stable all 5 cycles. Then both ops emerge in order with correct data; ready_i=0 while stalled with S0 full.
- Flush: two ops in flight plus valid_i on the flush cycle -> next cycle valid_o=0, no new op accepted, next accepted op flows normally.
- Illegal: opcode 0110011 or load funct3=3 -> valid_o=1, ls_func=0, be=0, tag_o=tag_i. With LS_MISALIGN_EN, LW at addr 0x1002 -> ls_func=0, misalign_o=1, addr_o=0x1002.
- Async reset asserted mid-stall -> valid_o and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ls_agu_p1.sv
// rtl/ls_agu_p1.sv - LS address-generation stage: decode, EA add, store lane/byte-enable formatting
// Optional feature macro: LS_MISALIGN_EN (misaligned half/word accesses become NOP with misalign_o=1)
module ls_agu_p1 #(
  parameter int PREG_W = 7,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_i,
  input  logic [PREG_W-1:0] rs1_i,
  input  logic [PREG_W-1:0] rs2_i,
  input  logic [PREG_W-1:0] rd_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              valid_i,
  output logic              ready_i,
  input  logic              flush_i,
  output logic [PREG_W-1:0] addra,
  output logic [PREG_W-1:0] addrb,
  input  logic [31:0]       dataa,
  input  logic [31:0]       datab,
  output logic              valid_o,
  input  logic              ready_o,
  output logic [3:0]        ls_func_o,
  output logic [31:0]       addr_o,
  output logic [31:0]       data_o,
  output logic [3:0]        be_o,
  output logic [PREG_W-1:0] rd_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              misalign_o
);

  localparam logic [3:0] F_NOP = 4'd0;
  localparam logic [3:0] F_LB  = 4'd1;
  localparam logic [3:0] F_LH  = 4'd2;
  localparam logic [3:0] F_LW  = 4'd3;
  localparam logic [3:0] F_LBU = 4'd4;
  localparam logic [3:0] F_LHU = 4'd5;
  localparam logic [3:0] F_SB  = 4'd6;
  localparam logic [3:0] F_SH  = 4'd7;
  localparam logic [3:0] F_SW  = 4'd8;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // S0 stage
  logic              r_valid0;
  logic [3:0]        r_func0;
  logic [31:0]       r_imm0;
  logic [PREG_W-1:0] r_rd0;
  logic [TAG_W-1:0]  r_tag0;

  // operand hold for a stalled S0
  logic              r_hold_vld;
  logic [31:0]       r_hold_a;
  logic [31:0]       r_hold_b;

  logic w_advance;
  logic w_accept;
  logic [3:0]  w_dec_func;
  logic [31:0] w_dec_imm;
  logic [31:0] w_opa;
  logic [31:0] w_opb;
  logic [31:0] w_addr;
  logic [3:0]  w_func;
  logic [3:0]  w_be;
  logic [31:0] w_data;
  logic        w_mis;
  logic        w_unused_bits;

  // rs1/rs2 fields come from the renamed physical indices, not the raw word
  assign w_unused_bits = ^instr_i[19:15];

  assign addra = rs1_i;
  assign addrb = rs2_i;

  assign w_advance = r_valid0 && (!valid_o || ready_o);
  assign ready_i   = !flush_i && (!r_valid0 || w_advance);
  assign w_accept  = valid_i && ready_i;

  // decode LS function and immediate from the incoming instruction word
  always_comb begin
    w_dec_func = F_NOP;
    w_dec_imm  = {{20{instr_i[31]}}, instr_i[31:20]};
    if (instr_i[6:0] == OP_LOAD) begin
      case (instr_i[14:12])
        3'd0:    w_dec_func = F_LB;
        3'd1:    w_dec_func = F_LH;
        3'd2:    w_dec_func = F_LW;
        3'd4:    w_dec_func = F_LBU;
        3'd5:    w_dec_func = F_LHU;
        default: w_dec_func = F_NOP;
      endcase
    end else if (instr_i[6:0] == OP_STORE) begin
      w_dec_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      case (instr_i[14:12])
        3'd0:    w_dec_func = F_SB;
        3'd1:    w_dec_func = F_SH;
        3'd2:    w_dec_func = F_SW;
        default: w_dec_func = F_NOP;
      endcase
    end
  end

  // effective address, byte enables and store lane replication for the op leaving S0
  always_comb begin
    w_opa  = r_hold_vld ? r_hold_a : dataa;
    w_opb  = r_hold_vld ? r_hold_b : datab;
    w_addr = w_opa + r_imm0;
    w_func = r_func0;
    w_be   = 4'b0000;
    w_data = 32'd0;
    w_mis  = 1'b0;
    case (r_func0)
      F_LB, F_LBU, F_SB: w_be = 4'b0001 << w_addr[1:0];
      F_LH, F_LHU, F_SH: w_be = 4'b0011 << {w_addr[1], 1'b0};
      F_LW, F_SW:        w_be = 4'b1111;
      default:           w_be = 4'b0000;
    endcase
    case (r_func0)
      F_SB:    w_data = {4{w_opb[7:0]}};
      F_SH:    w_data = {2{w_opb[15:0]}};
      F_SW:    w_data = w_opb;
      default: w_data = 32'd0;
    endcase
`ifdef LS_MISALIGN_EN
    if (((r_func0 == F_LH || r_func0 == F_LHU || r_func0 == F_SH) && w_addr[0]) ||
        ((r_func0 == F_LW || r_func0 == F_SW) && (w_addr[1:0] != 2'b00))) begin
      w_mis  = 1'b1;
      w_func = F_NOP;
      w_be   = 4'b0000;
      w_data = 32'd0;
    end
`endif
  end

  // S0 register: flush wins, then a new accept overwrites, else drain on advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid0 <= 1'b0;
      r_func0  <= F_NOP;
      r_imm0   <= 32'd0;
      r_rd0    <= '0;
      r_tag0   <= '0;
    end else if (flush_i) begin
      r_valid0 <= 1'b0;
    end else if (w_accept) begin
      r_valid0 <= 1'b1;
      r_func0  <= w_dec_func;
      r_imm0   <= w_dec_imm;
      r_rd0    <= rd_i;
      r_tag0   <= tag_i;
    end else if (w_advance) begin
      r_valid0 <= 1'b0;
    end
  end

  // capture regfile data the first cycle a valid S0 op fails to advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_vld <= 1'b0;
      r_hold_a   <= 32'd0;
      r_hold_b   <= 32'd0;
    end else if (flush_i || w_advance) begin
      r_hold_vld <= 1'b0;
    end else if (r_valid0 && !r_hold_vld) begin
      r_hold_vld <= 1'b1;
      r_hold_a   <= dataa;
      r_hold_b   <= datab;
    end
  end

  // output packet register: load on advance, drop valid once consumed, hold while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_o    <= 1'b0;
      ls_func_o  <= F_NOP;
      addr_o     <= 32'd0;
      data_o     <= 32'd0;
      be_o       <= 4'b0000;
      rd_o       <= '0;
      tag_o      <= '0;
      misalign_o <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (w_advance) begin
      valid_o    <= 1'b1;
      ls_func_o  <= w_func;
      addr_o     <= w_addr;
      data_o     <= w_data;
      be_o       <= w_be;
      rd_o       <= r_rd0;
      tag_o      <= r_tag0;
      misalign_o <= w_mis;
    end else if (ready_o) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ls_agu_p1.sv
// tb/tb_ls_agu_p1.sv - directed self-checking bench for ls_agu_p1
module tb_ls_agu_p1;

  localparam int PREG_W = 7;
  localparam int TAG_W  = 6;

  logic              clk;
  logic              reset;
  logic [31:0]       instr_i;
  logic [PREG_W-1:0] rs1_i;
  logic [PREG_W-1:0] rs2_i;
  logic [PREG_W-1:0] rd_i;
  logic [TAG_W-1:0]  tag_i;
  logic              valid_i;
  logic              ready_i;
  logic              flush_i;
  logic [PREG_W-1:0] addra;
  logic [PREG_W-1:0] addrb;
  logic [31:0]       dataa;
  logic [31:0]       datab;
  logic              valid_o;
  logic              ready_o;
  logic [3:0]        ls_func_o;
  logic [31:0]       addr_o;
  logic [31:0]       data_o;
  logic [3:0]        be_o;
  logic [PREG_W-1:0] rd_o;
  logic [TAG_W-1:0]  tag_o;
  logic              misalign_o;

  int total;
  int bad;

  ls_agu_p1 #(.PREG_W(PREG_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .instr_i(instr_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rd_i(rd_i), .tag_i(tag_i), .valid_i(valid_i), .ready_i(ready_i), .flush_i(flush_i),
    .addra(addra), .addrb(addrb), .dataa(dataa), .datab(datab), .valid_o(valid_o),
    .ready_o(ready_o), .ls_func_o(ls_func_o), .addr_o(addr_o), .data_o(data_o),
    .be_o(be_o), .rd_o(rd_o), .tag_o(tag_o), .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic [31:0] ins, input int rd, input int tg);
    instr_i = ins;
    rs1_i   = 7'd5;
    rs2_i   = 7'd6;
    rd_i    = rd[PREG_W-1:0];
    tag_i   = tg[TAG_W-1:0];
    valid_i = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    instr_i = 32'd0; rs1_i = '0; rs2_i = '0; rd_i = '0; tag_i = '0;
    valid_i = 1'b0; flush_i = 1'b0; dataa = 32'd0; datab = 32'd0; ready_o = 1'b1;

    // reset state
    #1;
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_func", {28'd0, ls_func_o}, 32'd0);
    chk("rst_addr", addr_o, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_be", {28'd0, be_o}, 32'd0);
    chk("rst_rd_tag", {19'd0, rd_o, tag_o}, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready_i", {31'd0, ready_i}, 32'd1);

    // LW x3, 4(x5)
    drive_op(32'h0042A183, 3, 5);
    #1;
    chk("lw_addra", {25'd0, addra}, 32'd5);
    chk("lw_addrb", {25'd0, addrb}, 32'd6);
    @(negedge clk);
    valid_i = 1'b0; dataa = 32'h1000; datab = 32'h5555;
    @(negedge clk);
    dataa = 32'hBAD0BAD0;
    chk("lw_valid", {31'd0, valid_o}, 32'd1);
    chk("lw_func", {28'd0, ls_func_o}, 32'd3);
    chk("lw_addr", addr_o, 32'h1004);
    chk("lw_be", {28'd0, be_o}, 32'hF);
    chk("lw_data", data_o, 32'd0);
    chk("lw_rd", {25'd0, rd_o}, 32'd3);
    chk("lw_tag", {26'd0, tag_o}, 32'd5);
    @(negedge clk);
    chk("lw_drain", {31'd0, valid_o}, 32'd0);

    // SB x6, -1(x5)
    drive_op(32'hFE628FA3, 0, 7);
    @(negedge clk);
    valid_i = 1'b0; dataa = 32'h2001; datab = 32'hDEADBEAB;
    @(negedge clk);
    chk("sb_valid", {31'd0, valid_o}, 32'd1);
    chk("sb_func", {28'd0, ls_func_o}, 32'd6);
    chk("sb_addr", addr_o, 32'h2000);
    chk("sb_data", data_o, 32'hABABABAB);
    chk("sb_be", {28'd0, be_o}, 32'h1);
    chk("sb_tag", {26'd0, tag_o}, 32'd7);
    @(negedge clk);

    // back-pressure: SH then LW, LSU stalled
    ready_o = 1'b0;
    drive_op(32'h00629023, 0, 10);
    @(negedge clk);
    drive_op(32'h0002A183, 4, 11);
    dataa = 32'h3002; datab = 32'h1234;
    @(negedge clk);
    valid_i = 1'b0; dataa = 32'h4000; datab = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", {31'd0, valid_o}, 32'd1);
      chk("bp_func", {28'd0, ls_func_o}, 32'd7);
      chk("bp_addr", addr_o, 32'h3002);
      chk("bp_be", {28'd0, be_o}, 32'hC);
      chk("bp_data", data_o, 32'h12341234);
      chk("bp_tag", {26'd0, tag_o}, 32'd10);
      chk("bp_ready_i", {31'd0, ready_i}, 32'd0);
      @(negedge clk);
      dataa = 32'hBAD00000 + i; datab = 32'hFEED0000 + i;
    end
    ready_o = 1'b1;
    @(negedge clk);
    chk("bp2_valid", {31'd0, valid_o}, 32'd1);
    chk("bp2_func", {28'd0, ls_func_o}, 32'd3);
    chk("bp2_addr", addr_o, 32'h4000);
    chk("bp2_be", {28'd0, be_o}, 32'hF);
    chk("bp2_tag", {26'd0, tag_o}, 32'd11);
    chk("bp2_rd", {25'd0, rd_o}, 32'd4);
    @(negedge clk);
    chk("bp2_drain", {31'd0, valid_o}, 32'd0);

    // illegal: R-type opcode
    drive_op(32'h005303B3, 1, 42);
    @(negedge clk);
    valid_i = 1'b0; dataa = 32'h10; datab = 32'h20;
    @(negedge clk);
    chk("ill_valid", {31'd0, valid_o}, 32'd1);
    chk("ill_func", {28'd0, ls_func_o}, 32'd0);
    chk("ill_be", {28'd0, be_o}, 32'd0);
    chk("ill_data", data_o, 32'd0);
    chk("ill_tag", {26'd0, tag_o}, 32'd42);

    // illegal: load funct3=3
    drive_op(32'h0002B183, 1, 43);
    @(negedge clk);
    valid_i = 1'b0; dataa = 32'h10;
    @(negedge clk);
    chk("ldf3_valid", {31'd0, valid_o}, 32'd1);
    chk("ldf3_func", {28'd0, ls_func_o}, 32'd0);
    chk("ldf3_be", {28'd0, be_o}, 32'd0);
    chk("ldf3_tag", {26'd0, tag_o}, 32'd43);

    // LW at misaligned address 0x1002
    drive_op(32'h0002A183, 2, 9);
    @(negedge clk);
    valid_i = 1'b0; dataa = 32'h1002;
    @(negedge clk);
    chk("mis_valid", {31'd0, valid_o}, 32'd1);
    chk("mis_addr", addr_o, 32'h1002);
    chk("mis_tag", {26'd0, tag_o}, 32'd9);
`ifdef LS_MISALIGN_EN
    chk("mis_func", {28'd0, ls_func_o}, 32'd0);
    chk("mis_be", {28'd0, be_o}, 32'd0);
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
`else
    chk("mis_func", {28'd0, ls_func_o}, 32'd3);
    chk("mis_be", {28'd0, be_o}, 32'hF);
    chk("mis_flag", {31'd0, misalign_o}, 32'd0);
`endif
    @(negedge clk);

    // flush with two ops in flight and a new op offered on the flush cycle
    ready_o = 1'b0;
    drive_op(32'h0002A183, 1, 1);
    @(negedge clk);
    drive_op(32'h0062A023, 1, 2);
    dataa = 32'h100;
    @(negedge clk);
    chk("fl_pre_valid", {31'd0, valid_o}, 32'd1);
    chk("fl_pre_tag", {26'd0, tag_o}, 32'd1);
    drive_op(32'h0002A183, 1, 3);
    flush_i = 1'b1; dataa = 32'h200;
    #1;
    chk("fl_ready_i", {31'd0, ready_i}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0; ready_o = 1'b1;
    chk("fl_valid0", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    chk("fl_valid1", {31'd0, valid_o}, 32'd0);
    drive_op(32'h0002A183, 1, 4);
    @(negedge clk);
    valid_i = 1'b0; dataa = 32'h5000;
    @(negedge clk);
    chk("fl_post_valid", {31'd0, valid_o}, 32'd1);
    chk("fl_post_tag", {26'd0, tag_o}, 32'd4);
    chk("fl_post_addr", addr_o, 32'h5000);
    @(negedge clk);

    // async reset during a stall
    ready_o = 1'b0;
    drive_op(32'hFE628FA3, 0, 12);
    @(negedge clk);
    valid_i = 1'b0; dataa = 32'h2001; datab = 32'hDEADBEAB;
    @(negedge clk);
    chk("ar_pre_valid", {31'd0, valid_o}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", {31'd0, valid_o}, 32'd0);
    chk("ar_func", {28'd0, ls_func_o}, 32'd0);
    chk("ar_addr", addr_o, 32'd0);
    chk("ar_data", data_o, 32'd0);
    chk("ar_be", {28'd0, be_o}, 32'd0);
    chk("ar_tag", {26'd0, tag_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
